// File: rtl/reg_dump.sv
// reg_dump: walks a register file read port from FIRST_REG to LAST_REG and
// streams each captured value, with its index, over a valid/ready interface.
// A pass is started by a start pulse in IDLE. It ends with a one-cycle done
// pulse, or it is dropped silently on abort or reset.
module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        busy,
    output logic        done
);

    // A reversed or out-of-range window cannot be walked, so refuse to build it.
    if (FIRST_REG > LAST_REG) begin : g_bad_range
        $error("reg_dump: FIRST_REG (%0d) must not exceed LAST_REG (%0d)", FIRST_REG, LAST_REG);
    end
    if (FIRST_REG < 0 || LAST_REG > 31) begin : g_bad_bounds
        $error("reg_dump: register window must lie within 0..31");
    end

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [4:0]  idx_d;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [4:0]  out_index_q;

    // The index register drives the read port directly. The increment is only
    // taken below LAST_IDX, so it never wraps.
    assign idx_d     = idx_q + 5'd1;
    assign rd_addr   = idx_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    // Main sequencer. Reading rd_data only in FETCH means later writes to the
    // register file cannot disturb a word that is waiting for out_ready. An
    // abort outranks a handshake in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= FIRST_IDX;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_index_q <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= FIRST_IDX;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_data_q  <= rd_data;
                        out_index_q <= idx_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_d;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: randomized bench for reg_dump. Each pass pushes the words it
// expects into a queue. A separate monitor pops one entry whenever the DUT
// completes a handshake, and it also checks that a stalled word stays stable.
module tb_reg_dump;

    typedef struct {
        logic [4:0]  index;
        logic [31:0] data;
    } word_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  rdAddr;
    logic [31:0] rdData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [4:0]  outIndex;
    logic        busy;
    logic        done;

    logic        start1;
    logic        abort1;
    logic [4:0]  rdAddr1;
    logic [31:0] rdData1;
    logic        valid1;
    logic        ready1;
    logic [31:0] data1;
    logic [4:0]  index1;
    logic        busy1;
    logic        done1;

    logic [31:0] regs [32];
    word_t       expQ [$];
    int          errors;
    int          checks;
    int          doneCount;

    assign rdData  = regs[rdAddr];
    assign rdData1 = (rdAddr1 == 5'd5) ? 32'hDEADBEEF : 32'h0;

    reg_dump dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rd_addr(rdAddr), .rd_data(rdData),
        .out_valid(outValid), .out_ready(outReady),
        .out_data(outData), .out_index(outIndex),
        .busy(busy), .done(done)
    );

    reg_dump #(.FIRST_REG(5), .LAST_REG(5)) dutSingle (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .rd_addr(rdAddr1), .rd_data(rdData1),
        .out_valid(valid1), .out_ready(ready1),
        .out_data(data1), .out_index(index1),
        .busy(busy1), .done(done1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a full pass yields every register in the window, in
    // order, with the value held in the register file when the pass starts.
    task automatic applyStimulus(input int firstReg, input int lastReg);
        for (int i = firstReg; i <= lastReg; i++) begin
            word_t w;
            w.index = 5'(i);
            w.data  = regs[i];
            expQ.push_back(w);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    task automatic waitWord(input string name, input logic [4:0] target);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (outValid && outIndex == target) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    // Monitor: pops an expected word on every accepted handshake, and checks
    // that a word not taken by the sink is held unchanged into the next cycle.
    initial begin
        bit          prevStall;
        logic [31:0] prevData;
        logic [4:0]  prevIndex;
        word_t       e;
        prevStall = 1'b0;
        prevData  = 32'd0;
        prevIndex = 5'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_valid", 32'(outValid), 32'd1);
                    checkOutput("stall_data", outData, prevData);
                    checkOutput("stall_index", 32'(outIndex), 32'(prevIndex));
                end
                if (outValid && outReady && !abort) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got index %0d data 0x%08h, expected none", outIndex, outData);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("word_index", 32'(outIndex), 32'(e.index));
                        checkOutput("word_data", outData, e.data);
                    end
                end
                if (done) doneCount++;
                prevStall = outValid && !outReady && !abort;
                prevData  = outData;
                prevIndex = outIndex;
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int    edges;
        int    stallLeft;
        bit    stalled7;
        errors    = 0;
        checks    = 0;
        doneCount = 0;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        outReady  = 1'b0;
        start1    = 1'b0;
        abort1    = 1'b0;
        ready1    = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;

        // Reset state, seen before any clock edge.
        #2;
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_data", outData, 32'd0);
        checkOutput("rst_index", 32'(outIndex), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_addr", 32'(rdAddr), 32'd0);
        checkOutput("rst_addr_single", 32'(rdAddr1), 32'd5);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;

        // Full pass with the sink always ready: latency and done timing.
        outReady = 1'b1;
        for (int i = 0; i < 32; i++) begin
            word_t w;
            w.index = 5'(i);
            w.data  = regs[i];
            expQ.push_back(w);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checkOutput("lat_busy_e1", 32'(busy), 32'd1);
        checkOutput("lat_valid_e1", 32'(outValid), 32'd0);
        @(posedge clk); #1;
        checkOutput("lat_valid_e2", 32'(outValid), 32'd1);
        edges = 2;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("done_edge", 32'(edges), 32'd65);
        @(posedge clk); #1;
        checkOutput("done_pulse_end", 32'(done), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("pass1_queue", 32'(expQ.size()), 32'd0);
        checkOutput("pass1_dones", 32'(doneCount), 32'd1);

        // Random back-pressure, with a 5-cycle stall on index 7. Its register is
        // overwritten during the stall, which must not change the held word.
        for (int i = 0; i < 32; i++) begin
            word_t w;
            w.index = 5'(i);
            w.data  = regs[i];
            expQ.push_back(w);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        stallLeft = 0;
        stalled7  = 1'b0;
        edges     = 0;
        while (!done && edges < 600) begin
            if (stallLeft > 0) begin
                outReady = 1'b0;
                checkOutput("stall7_data", outData, 32'h77777777);
                checkOutput("stall7_valid", 32'(outValid), 32'd1);
                stallLeft--;
            end else if (outValid && outIndex == 5'd7 && !stalled7) begin
                stalled7 = 1'b1;
                stallLeft = 4;
                outReady = 1'b0;
                regs[7]  = 32'hA5A5A5A5;
                checkOutput("stall7_data", outData, 32'h77777777);
            end else begin
                outReady = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("pass2_done", 32'(done), 32'd1);
        checkOutput("pass2_stalled", 32'(stalled7), 32'd1);
        regs[7]  = 32'h77777777;
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("pass2_queue", 32'(expQ.size()), 32'd0);
        checkOutput("pass2_dones", 32'(doneCount), 32'd2);

        // Abort at index 10 while the sink is ready; a second start mid-pass
        // must be ignored.
        for (int i = 0; i < 32; i++) begin
            word_t w;
            w.index = 5'(i);
            w.data  = regs[i];
            expQ.push_back(w);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        waitWord("abort_reach10", 5'd10);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        checkOutput("abort_valid", 32'(outValid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_queue", 32'(expQ.size()), 32'd22);
        if (expQ.size() > 0) checkOutput("abort_next", 32'(expQ[0].index), 32'd10);
        expQ.delete();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_stays_idle", 32'(busy), 32'd0);
        checkOutput("abort_dones", 32'(doneCount), 32'd2);

        // Asynchronous reset between edges at index 3, then a fresh pass.
        applyStimulus(0, 31);
        waitWord("reset_reach3", 5'd3);
        #3 reset = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(outValid), 32'd0);
        checkOutput("arst_data", outData, 32'd0);
        checkOutput("arst_index", 32'(outIndex), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_addr", 32'(rdAddr), 32'd0);
        checkOutput("arst_queue", 32'(expQ.size()), 32'd29);
        expQ.delete();
        @(posedge clk); #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("arst_waits_idle", 32'(busy), 32'd0);
        applyStimulus(0, 31);
        waitDone("pass4_done", 200);
        @(posedge clk); #1;
        checkOutput("pass4_queue", 32'(expQ.size()), 32'd0);
        checkOutput("pass4_dones", 32'(doneCount), 32'd3);

        // Single-register window on the second instance.
        ready1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        checkOutput("single_valid_e1", 32'(valid1), 32'd0);
        @(posedge clk); #1;
        checkOutput("single_valid_e2", 32'(valid1), 32'd1);
        checkOutput("single_index", 32'(index1), 32'd5);
        checkOutput("single_data", data1, 32'hDEADBEEF);
        checkOutput("single_nodone", 32'(done1), 32'd0);
        @(posedge clk); #1;
        checkOutput("single_done", 32'(done1), 32'd1);
        checkOutput("single_valid_off", 32'(valid1), 32'd0);
        @(posedge clk); #1;
        checkOutput("single_done_end", 32'(done1), 32'd0);
        checkOutput("single_idle", 32'(busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
